// File: rtl/nn_layer_unit.sv
// nn_layer_unit: LANES parallel fixed-point neurons sharing one x stream.
// Three-stage pipeline: multiply -> bias/accumulate -> round, activate, saturate.
// Optional feature macro: NN_LEAKY_RELU_EN (leaky ReLU, slope 1/8) instead of ReLU.
module nn_layer_unit #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4,
  parameter int ACCW  = 2*DW+8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         x,
  input  logic                  x_v,
  input  logic                  x_l,
  input  logic [LANES*DW-1:0]   w,
  input  logic                  w_v,
  input  logic [LANES*DW-1:0]   b,
  output logic [LANES*DW-1:0]   y,
  output logic                  y_v,
  output logic [LANES-1:0]      sat
);

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // Rounding constant and output clamp bounds, all at ACCW+1 bits so the
  // rounding add can never wrap.
  localparam logic signed [ACCW:0] RND  = {{ACCW{1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [ACCW:0] YMAX = {{(ACCW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] YMIN = {{(ACCW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic                           beat_s;
  logic [LANES-1:0][2*DW-1:0]     prod_r;
  logic                           p_v_r;
  logic                           p_l_r;
  logic [LANES-1:0][ACCW-1:0]     acc_r;
  logic                           a_v_r;
  logic [0:0]                     state_r;
  logic [LANES-1:0][DW-1:0]       y_s;
  logic [LANES-1:0]               sat_s;
  logic [LANES-1:0][DW-1:0]       y_r;
  logic                           y_v_r;
  logic [LANES-1:0]               sat_r;

  // Round half up, activate, then clamp to the DW-bit signed range.
  // Returns {clamped, value}.
  function automatic logic [DW:0] activate(input logic [ACCW-1:0] a);
    logic signed [ACCW:0] r;
    logic signed [ACCW:0] v;
    logic                 clamp;
    logic [DW-1:0]        q;
    r = $signed({a[ACCW-1], a}) + RND;
    r = r >>> FRAC;
`ifdef NN_LEAKY_RELU_EN
    v = r[ACCW] ? (r >>> 3) : r;
`else
    v = r[ACCW] ? {(ACCW+1){1'b0}} : r;
`endif
    if (v > YMAX) begin
      q     = YMAX[DW-1:0];
      clamp = 1'b1;
    end else if (v < YMIN) begin
      q     = YMIN[DW-1:0];
      clamp = 1'b1;
    end else begin
      q     = v[DW-1:0];
      clamp = 1'b0;
    end
    return {clamp, q};
  endfunction

  assign beat_s = x_v & w_v;

  // Stage 1: register per-lane products; products hold when there is no beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r <= '0;
      p_v_r  <= 1'b0;
      p_l_r  <= 1'b0;
    end else begin
      p_v_r <= beat_s;
      p_l_r <= beat_s & x_l;
      if (beat_s) begin
        for (int i = 0; i < LANES; i++) begin
          prod_r[i] <= (2*DW)'($signed(x)) * (2*DW)'($signed(w[i*DW +: DW]));
        end
      end else begin
        prod_r <= prod_r;
      end
    end
  end

  // Stage 2: seed with scaled bias on the first product, else accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= '0;
      a_v_r   <= 1'b0;
      state_r <= ST_FIRST;
    end else begin
      a_v_r <= p_v_r & p_l_r;
      if (p_v_r) begin
        for (int i = 0; i < LANES; i++) begin
          if (state_r == ST_FIRST) begin
            acc_r[i] <= (ACCW'($signed(b[i*DW +: DW])) <<< FRAC) +
                        ACCW'($signed(prod_r[i]));
          end else begin
            acc_r[i] <= acc_r[i] + ACCW'($signed(prod_r[i]));
          end
        end
        state_r <= p_l_r ? ST_FIRST : ST_ACCUM;
      end else begin
        acc_r   <= acc_r;
        state_r <= state_r;
      end
    end
  end

  // Per-lane activation of the finished accumulators.
  always_comb begin
    y_s   = '0;
    sat_s = '0;
    for (int i = 0; i < LANES; i++) begin
      {sat_s[i], y_s[i]} = activate(acc_r[i]);
    end
  end

  // Stage 3: capture activated results; they hold until the next vector ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r   <= '0;
      sat_r <= '0;
      y_v_r <= 1'b0;
    end else begin
      y_v_r <= a_v_r;
      if (a_v_r) begin
        y_r   <= y_s;
        sat_r <= sat_s;
      end else begin
        y_r   <= y_r;
        sat_r <= sat_r;
      end
    end
  end

  assign y   = y_r;
  assign y_v = y_v_r;
  assign sat = sat_r;

endmodule

// File: tb/tb_nn_layer_unit.sv
// Self-checking bench for nn_layer_unit: directed vectors plus randomized
// traffic against a vector-level arithmetic reference model.
module tb_nn_layer_unit;

  localparam int DW = 16;
  localparam int FRAC = 8;
  localparam int LANES = 4;
  localparam int ACCW = 2*DW+8;

  typedef longint lane_t [LANES];
  typedef struct {
    int          due;
    logic [63:0] yv;
    logic [3:0]  sv;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DW-1:0]       x = '0;
  logic                x_v = 1'b0;
  logic                x_l = 1'b0;
  logic [LANES*DW-1:0] w = '0;
  logic                w_v = 1'b0;
  logic [LANES*DW-1:0] b = '0;
  logic [LANES*DW-1:0] y;
  logic                y_v;
  logic [LANES-1:0]    sat;

  int n_chk = 0;
  int n_fail = 0;
  int cnt = 0;

  exp_t        exp_q[$];
  logic [63:0] last_y = '0;
  logic [3:0]  last_sat = '0;

  bit    open_m = 0;
  bit    wait_b = 0;
  bit    wait_done = 0;
  int    done_due = 0;
  lane_t cur_sum, cur_bias, done_sum;

  nn_layer_unit #(.DW(DW), .FRAC(FRAC), .LANES(LANES), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .x_v(x_v), .x_l(x_l),
    .w(w), .w_v(w_v), .b(b), .y(y), .y_v(y_v), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, expv, cnt);
    end
  endtask

  // Reference: bias*2^FRAC + sum of products, wrapped to ACCW bits, rounded
  // half up, activated and clamped.
  task automatic finalize(input lane_t s, input lane_t bb, input int due);
    exp_t   e;
    longint t, r, mask;
    e.due = due;
    e.yv = '0;
    e.sv = '0;
    mask = (64'sd1 <<< ACCW) - 64'sd1;
    for (int i = 0; i < LANES; i++) begin
      t = (bb[i] * 64'sd256) + s[i];
      t = t & mask;
      if (t[ACCW-1]) t = t | ~mask;
      r = (t + 64'sd128) >>> FRAC;
`ifdef NN_LEAKY_RELU_EN
      if (r < 0) r = r >>> 3;
`else
      if (r < 0) r = 0;
`endif
      if (r > 64'sd32767) begin
        r = 64'sd32767; e.sv[i] = 1'b1;
      end else if (r < -64'sd32768) begin
        r = -64'sd32768; e.sv[i] = 1'b1;
      end
      e.yv[i*16 +: 16] = r[15:0];
    end
    exp_q.push_back(e);
  endtask

  // Advance the model by one clock edge using the values just driven.
  task automatic model_step();
    lane_t bias;
    if (wait_b) begin
      for (int i = 0; i < LANES; i++) bias[i] = longint'($signed(b[i*DW +: DW]));
      if (wait_done) finalize(done_sum, bias, done_due);
      else cur_bias = bias;
      wait_b = 0;
      wait_done = 0;
    end
    if (x_v && w_v) begin
      if (!open_m) begin
        open_m = 1;
        wait_b = 1;
        for (int i = 0; i < LANES; i++) cur_sum[i] = 0;
      end
      for (int i = 0; i < LANES; i++)
        cur_sum[i] += longint'($signed(x)) * longint'($signed(w[i*DW +: DW]));
      if (x_l) begin
        open_m = 0;
        if (wait_b) begin
          done_sum = cur_sum;
          done_due = cnt + 2;
          wait_done = 1;
        end else begin
          finalize(cur_sum, cur_bias, cnt + 2);
        end
      end
    end
  endtask

  task automatic drive(input logic xv, input logic xl, input logic [15:0] xx,
                       input logic [63:0] ww, input logic wv, input logic [63:0] bb);
    x_v = xv; x_l = xl; x = xx; w = ww; w_v = wv; b = bb;
    @(posedge clk);
    cnt++;
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_y", y, 64'h0);
    check("rst_yv", {63'h0, y_v}, 64'h0);
    check("rst_sat", {60'h0, sat}, 64'h0);
    exp_q.delete();
    open_m = 0; wait_b = 0; wait_done = 0;
    last_y = '0; last_sat = '0;
    idle(2);
    rst_n = 1'b1;
  endtask

  // Output monitor: every y_v must match the next expectation on its due
  // edge, and y/sat must hold between pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (y_v) begin
        if (exp_q.size() == 0) begin
          check("spurious_yv", 64'h1, 64'h0);
        end else begin
          check("yv_time", 64'(cnt), 64'(exp_q[0].due));
          check("y", y, exp_q[0].yv);
          check("sat", {60'h0, sat}, {60'h0, exp_q[0].sv});
          last_y = exp_q[0].yv;
          last_sat = exp_q[0].sv;
          void'(exp_q.pop_front());
        end
      end else begin
        check("y_hold", y, last_y);
        check("sat_hold", {60'h0, sat}, {60'h0, last_sat});
        if (exp_q.size() != 0 && exp_q[0].due <= cnt) begin
          check("missing_yv", 64'h0, 64'h1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [15:0] rx;
    logic [63:0] rw, rb;
    do_reset();

    // Three beats of 1.0*2.0 per lane.
    for (int i = 0; i < 3; i++)
      drive(1'b1, i == 2, 16'h0100, 64'h0200_0200_0200_0200, 1'b1, 64'h0);
    idle(4);
    check("req028_y", y, 64'h0600_0600_0600_0600);
    check("req028_sat", {60'h0, sat}, 64'h0);

    // Negative lane activation and bias on lane 1.
    for (int i = 0; i < 2; i++)
      drive(1'b1, i == 1, 16'h0100, 64'h0000_0000_0080_FF00, 1'b1, 64'h0000_0000_0100_0000);
    idle(4);
`ifdef NN_LEAKY_RELU_EN
    check("req029_y", y, 64'h0000_0000_0200_FFC0);
`else
    check("req029_y", y, 64'h0000_0000_0200_0000);
`endif

    // Full-scale operands saturate every lane.
    for (int i = 0; i < 4; i++)
      drive(1'b1, i == 3, 16'h7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1, 64'h0);
    idle(4);
    check("req030_y", y, 64'h7FFF_7FFF_7FFF_7FFF);
    check("req030_sat", {60'h0, sat}, 64'hF);

    // w_v toggling; x_l on non-beat cycles must be ignored.
    drive(1'b1, 1'b0, 16'h0100, 64'h0100_0100_0100_0100, 1'b1, 64'h0);
    drive(1'b1, 1'b1, 16'h0100, 64'h0100_0100_0100_0100, 1'b0, 64'h0);
    drive(1'b1, 1'b1, 16'h0100, 64'h0100_0100_0100_0100, 1'b1, 64'h0);
    drive(1'b1, 1'b0, 16'h0100, 64'h0100_0100_0100_0100, 1'b0, 64'h0);
    drive(1'b1, 1'b1, 16'h0100, 64'h0100_0100_0100_0100, 1'b0, 64'h0);
    idle(4);
    check("req031_y", y, 64'h0200_0200_0200_0200);

    // Back-to-back single-beat vectors.
    drive(1'b1, 1'b1, 16'h0100, 64'h0100_0100_0100_0100, 1'b1, 64'h0);
    drive(1'b1, 1'b1, 16'h0200, 64'h0100_0100_0100_0100, 1'b1, 64'h0);
    idle(4);
    check("req032_y", y, 64'h0200_0200_0200_0200);

    // Reset mid-vector discards the partial sum.
    drive(1'b1, 1'b0, 16'h0100, 64'h0100_0100_0100_0100, 1'b1, 64'h0);
    drive(1'b1, 1'b0, 16'h0100, 64'h0100_0100_0100_0100, 1'b1, 64'h0);
    do_reset();
    drive(1'b1, 1'b1, 16'h0100, 64'h0300_0300_0300_0300, 1'b1, 64'h0);
    idle(4);
    check("req033_y", y, 64'h0300_0300_0300_0300);

    // Randomized traffic: small values mostly, occasional full scale.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx = 16'($urandom);
        rw = {$urandom, $urandom};
        rb = {$urandom, $urandom};
      end else begin
        rx = 16'($signed(8'($urandom)));
        rw = '0; rb = '0;
        for (int i = 0; i < LANES; i++) begin
          rw[i*16 +: 16] = 16'($signed(10'($urandom)));
          rb[i*16 +: 16] = 16'($signed(10'($urandom)));
        end
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, rx, rw,
                 $urandom_range(0, 9) < 8, rb);
    end
    idle(6);
    check("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
